// File: rtl/sfr_arb_pkg.sv
// Shared types and constants for the SFR bus arbiter slice.
package sfr_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ACK    = 2'd2
  } state_t;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin picker; masked requesters never win.
module rr_arb2
  import sfr_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  input  logic [1:0] mask,
  output logic       gnt_valid,
  output logic       gnt_idx
);

  logic [1:0] w_req;

  always_comb begin
    w_req     = req & ~mask;
    gnt_valid = |w_req;
    gnt_idx   = M0;
    unique case (w_req)
      2'b01:   gnt_idx = M0;
      2'b10:   gnt_idx = M1;
      2'b11:   gnt_idx = ~last;
      default: gnt_idx = M0;
    endcase
  end

endmodule

// File: rtl/sfr_arb.sv
// Two-master SFR bus arbiter/sequencer: one access at a time, round-robin
// grants, fully registered bus outputs and a one-cycle ack with read data.
module sfr_arb
  import sfr_arb_pkg::*;
#(
  parameter int AW = 8,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          m0_req,
  input  logic [AW-1:0] m0_addr,
  input  logic          m0_r,
  input  logic [1:0]    m0_w,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_ack,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic [AW-1:0] m1_addr,
  input  logic          m1_r,
  input  logic [1:0]    m1_w,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_ack,
  output logic [DW-1:0] m1_rdata,
  output logic          sfr_sel,
  output logic [AW-1:0] sfr_addr,
  output logic          sfr_r,
  output logic [1:0]    sfr_w,
  output logic [DW-1:0] sfr_dwrite,
  input  logic [DW-1:0] sfr_rdata
);

  state_t     r_state, w_next;
  logic       r_last;
  logic       r_cur;
  logic [1:0] w_mask;
  logic       w_gnt_valid;
  logic       w_gnt_idx;
  logic       w_grant;

  // The master acked in ACK must not be re-granted in the same cycle.
  always_comb begin
    w_mask = '0;
    if (r_state == ACK)
      w_mask = (r_last == M1) ? 2'b10 : 2'b01;
  end

  rr_arb2 u_rr_arb2 (
    .req       ({m1_req, m0_req}),
    .last      (r_last),
    .mask      (w_mask),
    .gnt_valid (w_gnt_valid),
    .gnt_idx   (w_gnt_idx)
  );

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) r_state <= IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_grant = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_gnt_valid) begin
          w_grant = 1'b1;
          w_next  = ACCESS;
        end
      end
      ACCESS: w_next = ACK;
      ACK: begin
        if (w_gnt_valid) begin
          w_grant = 1'b1;
          w_next  = ACCESS;
        end else begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_last     <= M1;
      r_cur      <= M0;
      sfr_sel    <= 1'b0;
      sfr_addr   <= '0;
      sfr_r      <= 1'b0;
      sfr_w      <= '0;
      sfr_dwrite <= '0;
      m0_ack     <= 1'b0;
      m1_ack     <= 1'b0;
      m0_rdata   <= '0;
      m1_rdata   <= '0;
    end else begin
      m0_ack <= (r_state == ACCESS) && (r_cur == M0);
      m1_ack <= (r_state == ACCESS) && (r_cur == M1);
      if (w_grant) begin
        r_cur      <= w_gnt_idx;
        sfr_sel    <= 1'b1;
        sfr_addr   <= (w_gnt_idx == M1) ? m1_addr  : m0_addr;
        sfr_r      <= (w_gnt_idx == M1) ? m1_r     : m0_r;
        sfr_w      <= (w_gnt_idx == M1) ? m1_w     : m0_w;
        sfr_dwrite <= (w_gnt_idx == M1) ? m1_wdata : m0_wdata;
      end else if (r_state == ACCESS) begin
        r_last     <= r_cur;
        sfr_sel    <= 1'b0;
        sfr_addr   <= '0;
        sfr_r      <= 1'b0;
        sfr_w      <= '0;
        sfr_dwrite <= '0;
        if (r_cur == M1) m1_rdata <= sfr_rdata;
        else             m0_rdata <= sfr_rdata;
      end
    end
  end

endmodule

// File: tb/tb_sfr_arb.sv
// Scoreboard bench for sfr_arb with a byte-lane SFR memory model.
module tb_sfr_arb;

  localparam int AW = 8;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          nreset;
  logic          m0_req, m0_r, m0_ack, m1_req, m1_r, m1_ack;
  logic [AW-1:0] m0_addr, m1_addr, sfr_addr;
  logic [1:0]    m0_w, m1_w, sfr_w;
  logic [DW-1:0] m0_wdata, m1_wdata, m0_rdata, m1_rdata;
  logic          sfr_sel, sfr_r;
  logic [DW-1:0] sfr_dwrite, sfr_rdata;

  always #5 clk = ~clk;

  sfr_arb #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .nreset(nreset),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_r(m0_r), .m0_w(m0_w),
    .m0_wdata(m0_wdata), .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_r(m1_r), .m1_w(m1_w),
    .m1_wdata(m1_wdata), .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .sfr_sel(sfr_sel), .sfr_addr(sfr_addr), .sfr_r(sfr_r), .sfr_w(sfr_w),
    .sfr_dwrite(sfr_dwrite), .sfr_rdata(sfr_rdata)
  );

  // SFR block: latches writes on the falling edge, reads combinationally.
  logic [DW-1:0] mem [256];
  always @(negedge clk) begin
    if (sfr_sel && sfr_w[0]) mem[sfr_addr][7:0]  <= sfr_dwrite[7:0];
    if (sfr_sel && sfr_w[1]) mem[sfr_addr][15:8] <= sfr_dwrite[15:8];
  end
  assign sfr_rdata = (sfr_sel && sfr_r) ? mem[sfr_addr] : '0;

  typedef struct {
    logic [7:0]  addr;
    logic        r;
    logic [1:0]  w;
    logic [15:0] wd;
  } bus_t;

  typedef struct {
    logic        m;
    logic [15:0] rd;
  } ack_t;

  bus_t bus_q[$];
  ack_t ack_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   gap_en = 1'b0;
  int   last_sel = -1;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic expect_txn(input bit m, input logic [7:0] a, input bit r,
                            input logic [1:0] w, input logic [15:0] wd,
                            input logic [15:0] rd);
    bus_t b;
    ack_t k;
    b.addr = a; b.r = r; b.w = w; b.wd = wd;
    k.m = m; k.rd = rd;
    bus_q.push_back(b);
    ack_q.push_back(k);
  endtask

  // Monitor: compares every bus pulse and every ack against the queues.
  always @(negedge clk) begin
    bus_t eb;
    ack_t ea;
    if (nreset) begin
      if (sfr_sel) begin
        if (bus_q.size() == 0) begin
          check("bus_unexpected_sel", sfr_sel, 0);
        end else begin
          eb = bus_q.pop_front();
          check("sfr_addr", sfr_addr, eb.addr);
          check("sfr_r", sfr_r, eb.r);
          check("sfr_w", sfr_w, eb.w);
          check("sfr_dwrite", sfr_dwrite, eb.wd);
        end
        if (last_sel >= 0) begin
          if (gap_en) check("sel_gap", cyc - last_sel, 2);
          else        check("sel_min_gap", (cyc - last_sel) >= 2, 1);
        end
        last_sel = cyc;
      end
      if (m0_ack || m1_ack) begin
        if (ack_q.size() == 0) begin
          check("ack_unexpected", {m1_ack, m0_ack}, 0);
        end else begin
          ea = ack_q.pop_front();
          check("ack_master", {m1_ack, m0_ack}, ea.m ? 2'b10 : 2'b01);
          check(ea.m ? "m1_rdata" : "m0_rdata", ea.m ? m1_rdata : m0_rdata, ea.rd);
        end
      end
    end
  end

  // Single-master transaction; fields are scrambled during ACCESS to show
  // they are only sampled on the grant edge.
  task automatic issue(input bit m, input logic [7:0] a, input bit r,
                       input logic [1:0] w, input logic [15:0] wd,
                       input logic [15:0] rd);
    int n;
    bit got;
    expect_txn(m, a, r, w, wd, rd);
    if (!m) begin m0_addr = a; m0_r = r; m0_w = w; m0_wdata = wd; m0_req = 1'b1; end
    else    begin m1_addr = a; m1_r = r; m1_w = w; m1_wdata = wd; m1_req = 1'b1; end
    n = 0;
    got = 1'b0;
    while (!got && n < 20) begin
      @(posedge clk); #1;
      n++;
      got = m ? m1_ack : m0_ack;
      if (n == 1) begin
        if (!m) begin m0_addr = ~a; m0_wdata = ~wd; m0_w = ~w; end
        else    begin m1_addr = ~a; m1_wdata = ~wd; m1_w = ~w; end
      end
    end
    check("ack_latency", n, 2);
    @(posedge clk); #1;
    if (!m) m0_req = 1'b0;
    else    m1_req = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic pulse_reset();
    nreset = 1'b0;
    m0_req = 1'b0;
    m1_req = 1'b0;
    repeat (2) @(posedge clk);
    #1 nreset = 1'b1;
    @(posedge clk); #1;
  endtask

  logic [7:0]  a0 [3] = '{8'h00, 8'h24, 8'h16};
  logic [15:0] e0 [3] = '{16'h1234, 16'h11CD, 16'h5A5A};
  logic [7:0]  a1 [3] = '{8'h16, 8'h00, 8'h24};
  logic [15:0] e1 [3] = '{16'h5A5A, 16'h1234, 16'h11CD};

  initial begin
    nreset = 1'b0;
    m0_req = 1'b0; m0_addr = '0; m0_r = 1'b0; m0_w = '0; m0_wdata = '0;
    m1_req = 1'b0; m1_addr = '0; m1_r = 1'b0; m1_w = '0; m1_wdata = '0;
    #12;
    check("rst_bus", {sfr_sel, sfr_r, sfr_w, sfr_addr, sfr_dwrite}, 0);
    check("rst_ack", {m0_ack, m1_ack}, 0);
    check("rst_rdata", {m0_rdata, m1_rdata}, 0);
    @(posedge clk); #1 nreset = 1'b1;
    @(posedge clk); #1;
    check("rst_bus_after", {sfr_sel, sfr_r, sfr_w, sfr_addr, sfr_dwrite}, 0);

    issue(1'b0, 8'h00, 1'b0, 2'b11, 16'h1234, 16'h0000);
    issue(1'b0, 8'h00, 1'b1, 2'b00, 16'h0000, 16'h1234);
    issue(1'b0, 8'h24, 1'b0, 2'b11, 16'h1111, 16'h0000);
    issue(1'b0, 8'h24, 1'b0, 2'b01, 16'hABCD, 16'h0000);
    issue(1'b0, 8'h24, 1'b1, 2'b00, 16'h0000, 16'h11CD);
    issue(1'b1, 8'h16, 1'b0, 2'b11, 16'h5A5A, 16'h0000);
    issue(1'b1, 8'h16, 1'b1, 2'b00, 16'h0000, 16'h5A5A);
    check("m1_rdata_hold", m1_rdata, 16'h5A5A);
    check("m1_ack_low_after", m1_ack, 0);

    pulse_reset();
    check("rdata_cleared", {m0_rdata, m1_rdata}, 0);
    for (int i = 0; i < 3; i++) begin
      expect_txn(1'b0, a0[i], 1'b1, 2'b00, 16'h0000, e0[i]);
      expect_txn(1'b1, a1[i], 1'b1, 2'b00, 16'h0000, e1[i]);
    end
    last_sel = -1;
    gap_en = 1'b1;
    fork
      begin
        for (int i = 0; i < 3; i++) begin
          int n;
          m0_addr = a0[i]; m0_r = 1'b1; m0_w = 2'b00; m0_wdata = '0; m0_req = 1'b1;
          n = 0;
          do begin @(posedge clk); #1; n++; end while (!m0_ack && n < 30);
          check("alt_m0_ack", m0_ack, 1);
          @(posedge clk); #1;
        end
        m0_req = 1'b0;
      end
      begin
        for (int j = 0; j < 3; j++) begin
          int n;
          m1_addr = a1[j]; m1_r = 1'b1; m1_w = 2'b00; m1_wdata = '0; m1_req = 1'b1;
          n = 0;
          do begin @(posedge clk); #1; n++; end while (!m1_ack && n < 30);
          check("alt_m1_ack", m1_ack, 1);
          @(posedge clk); #1;
        end
        m1_req = 1'b0;
      end
    join
    gap_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    m0_addr = 8'h40; m0_r = 1'b0; m0_w = 2'b11; m0_wdata = 16'hBEEF; m0_req = 1'b1;
    @(posedge clk); #1;
    check("mid_sel_high", sfr_sel, 1);
    #1 nreset = 1'b0;
    m0_req = 1'b0;
    #1;
    check("mid_rst_bus", {sfr_sel, sfr_r, sfr_w, sfr_addr, sfr_dwrite}, 0);
    @(posedge clk); #1 nreset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("mid_rst_no_ack", {m0_ack, m1_ack}, 0);
    end
    check("mid_rst_rdata", {m0_rdata, m1_rdata}, 0);
    issue(1'b1, 8'h00, 1'b1, 2'b00, 16'h0000, 16'h1234);

    repeat (3) @(posedge clk);
    check("bus_q_empty", bus_q.size(), 0);
    check("ack_q_empty", ack_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
